// File: rtl/addr_mode_sequencer.sv
// Operand-address sequencer for the 6502 core: after opcode fetch it walks
// the T1..T5 memory cycles of the eight bbb addressing modes and returns
// the effective address and the PC past the operand bytes.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   start           begin a sequence (accepted only while idle)
//   bbb             addressing mode (INX ZPG IMM ABS INY ZPX ABY ABX)
//   force_fix       always take the index fix-up cycle (store/RMW)
//   pc_in, x, y     operand PC and index registers, sampled with start
//   d_in            read data for addr, captured at the end of the cycle
//   addr, rd        registered bus address and read strobe
//   busy, done      sequence in progress / one-cycle completion pulse
//   ea, pc_out      effective address and updated PC
//   page_cross      index add carried out of the low byte
module addr_mode_sequencer #(
  parameter logic [7:0] ZP_BASE      = 8'h00,
  parameter logic       ZP_WRAP      = 1'b1,
  parameter logic       PAGE_PENALTY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  bbb,
  input  logic        force_fix,
  input  logic [15:0] pc_in,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  d_in,
  output logic [15:0] addr,
  output logic        rd,
  output logic        busy,
  output logic        done,
  output logic [15:0] ea,
  output logic [15:0] pc_out,
  output logic        page_cross
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C1   = 3'd1;
  localparam logic [2:0] S_C2   = 3'd2;
  localparam logic [2:0] S_C3   = 3'd3;
  localparam logic [2:0] S_C4   = 3'd4;

  localparam logic [2:0] M_INX = 3'b000;
  localparam logic [2:0] M_ZPG = 3'b001;
  localparam logic [2:0] M_IMM = 3'b010;
  localparam logic [2:0] M_ABS = 3'b011;
  localparam logic [2:0] M_INY = 3'b100;
  localparam logic [2:0] M_ZPX = 3'b101;
  localparam logic [2:0] M_ABY = 3'b110;
  localparam logic [2:0] M_ABX = 3'b111;

  logic [2:0]  state_q, state_n;
  logic [2:0]  mode_q, mode_n;
  logic        ff_q, ff_n;
  logic [15:0] pc_q, pc_n;
  logic [7:0]  x_q, x_n, y_q, y_n;
  logic [7:0]  ptr_q, ptr_n, lo_q, lo_n, hi_q, hi_n;
  logic [15:0] addr_n, ea_n, pc_out_n;
  logic        rd_n, busy_n, done_n, pcx_n;

  logic        fin, fin_pcx, fix;
  logic [15:0] fin_ea, fin_pc;
  logic [7:0]  idx;
  logic [8:0]  s;

  // Zero-page address of a 9-bit pointer value, wrapping or carrying per ZP_WRAP
  function automatic logic [15:0] zp(input logic [8:0] v);
    if (ZP_WRAP) zp = {ZP_BASE, v[7:0]};
    else         zp = {ZP_BASE, 8'h00} + 16'(v);
  endfunction

  // Index sum and fix-up decision shared by ABX/ABY/INY
  always_comb begin
    idx = ((mode_q == M_ABY) || (mode_q == M_INY)) ? y_q : x_q;
    s   = {1'b0, lo_q} + {1'b0, idx};
    fix = s[8] | ff_q | ~PAGE_PENALTY;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    ff_n     = ff_q;
    pc_n     = pc_q;
    x_n      = x_q;
    y_n      = y_q;
    ptr_n    = ptr_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    addr_n   = addr;
    rd_n     = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    ea_n     = ea;
    pc_out_n = pc_out;
    pcx_n    = page_cross;
    fin      = 1'b0;
    fin_ea   = 16'h0000;
    fin_pc   = pc_q + 16'd1;
    fin_pcx  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_n  = bbb;
          ff_n    = force_fix;
          pc_n    = pc_in;
          x_n     = x;
          y_n     = y;
          state_n = S_C1;
          busy_n  = 1'b1;
          if (bbb != M_IMM) begin
            addr_n = pc_in;
            rd_n   = 1'b1;
          end
        end
      end
      S_C1: begin
        lo_n  = d_in;
        ptr_n = d_in;
        case (mode_q)
          M_IMM: begin fin = 1'b1; fin_ea = pc_q; end
          M_ZPG: begin fin = 1'b1; fin_ea = {ZP_BASE, d_in}; end
          M_ZPX, M_INX: state_n = S_C2;
          M_INY: begin
            state_n = S_C2;
            addr_n  = zp({1'b0, d_in});
            rd_n    = 1'b1;
          end
          default: begin
            state_n = S_C2;
            addr_n  = pc_q + 16'd1;
            rd_n    = 1'b1;
          end
        endcase
      end
      S_C2: begin
        case (mode_q)
          M_ZPX: begin
            fin    = 1'b1;
            fin_ea = zp({1'b0, lo_q} + {1'b0, x_q});
          end
          M_ABS: begin
            fin    = 1'b1;
            fin_ea = {d_in, lo_q};
            fin_pc = pc_q + 16'd2;
          end
          M_ABX, M_ABY: begin
            hi_n = d_in;
            if (fix) begin
              state_n = S_C3;
              addr_n  = {d_in, s[7:0]};
              rd_n    = 1'b1;
            end else begin
              fin     = 1'b1;
              fin_ea  = {8'(d_in + {7'b0, s[8]}), s[7:0]};
              fin_pc  = pc_q + 16'd2;
              fin_pcx = s[8];
            end
          end
          M_INX: begin
            state_n = S_C3;
            addr_n  = zp({1'b0, ptr_q} + {1'b0, x_q});
            rd_n    = 1'b1;
          end
          default: begin
            // INY: low byte of the pointer target
            lo_n    = d_in;
            state_n = S_C3;
            addr_n  = zp({1'b0, ptr_q} + 9'd1);
            rd_n    = 1'b1;
          end
        endcase
      end
      S_C3: begin
        case (mode_q)
          M_INX: begin
            lo_n    = d_in;
            state_n = S_C4;
            addr_n  = zp({1'b0, ptr_q} + {1'b0, x_q} + 9'd1);
            rd_n    = 1'b1;
          end
          M_INY: begin
            hi_n = d_in;
            if (fix) begin
              state_n = S_C4;
              addr_n  = {d_in, s[7:0]};
              rd_n    = 1'b1;
            end else begin
              fin     = 1'b1;
              fin_ea  = {8'(d_in + {7'b0, s[8]}), s[7:0]};
              fin_pcx = s[8];
            end
          end
          default: begin
            // ABX/ABY after the fix-up dummy read
            fin     = 1'b1;
            fin_ea  = {8'(hi_q + {7'b0, s[8]}), s[7:0]};
            fin_pc  = pc_q + 16'd2;
            fin_pcx = s[8];
          end
        endcase
      end
      S_C4: begin
        fin = 1'b1;
        if (mode_q == M_INX) begin
          fin_ea = {d_in, lo_q};
        end else begin
          fin_ea  = {8'(hi_q + {7'b0, s[8]}), s[7:0]};
          fin_pcx = s[8];
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Completion: publish results, drop busy, pulse done
    if (fin) begin
      state_n  = S_IDLE;
      busy_n   = 1'b0;
      done_n   = 1'b1;
      rd_n     = 1'b0;
      ea_n     = fin_ea;
      pc_out_n = fin_pc;
      pcx_n    = fin_pcx;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 3'd0;
      ff_q       <= 1'b0;
      pc_q       <= 16'h0000;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      ptr_q      <= 8'h00;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      addr       <= 16'h0000;
      rd         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ea         <= 16'h0000;
      pc_out     <= 16'h0000;
      page_cross <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      ff_q       <= ff_n;
      pc_q       <= pc_n;
      x_q        <= x_n;
      y_q        <= y_n;
      ptr_q      <= ptr_n;
      lo_q       <= lo_n;
      hi_q       <= hi_n;
      addr       <= addr_n;
      rd         <= rd_n;
      busy       <= busy_n;
      done       <= done_n;
      ea         <= ea_n;
      pc_out     <= pc_out_n;
      page_cross <= pcx_n;
    end
  end

endmodule

// File: doc/addr_mode_sequencer.md
Name: addr_mode_sequencer

Overview:
- Parametrised operand-address sequencer for the 6502 core.
- After the opcode fetch (T0), it walks the memory cycles needed to resolve the effective address for all eight bbb addressing modes:
  - cycle-exact T1..T5 timing;
  - zero-page wrap;
  - page-cross penalty.
- It drives the address bus during those cycles and hands back the effective address and updated PC to the controller FSM.

Parameters:
- ZP_BASE, 8'h00, high byte of the zero page (for example, 8'h20 for relocated-zero-page variants).
- ZP_WRAP, 1, 1 = zero-page index and pointer arithmetic wraps within the page; 0 = carry propagates into the high byte.
- PAGE_PENALTY, 1, 1 = ABX/ABY/INY take the fix-up cycle only on page cross or when force_fix is set; 0 = fix-up cycle always taken.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin sequence; sampled only when not busy
- bbb  in  3  addressing mode: INX=000 ZPG=001 IMM=010 ABS=011 INY=100 ZPX=101 ABY=110 ABX=111
- force_fix  in  1  store/RMW: always take the fix-up cycle
- pc_in  in  16  PC of the first operand byte, sampled with start
- x  in  8  X index, sampled with start
- y  in  8  Y index, sampled with start
- d_in  in  8  read data for the current addr, sampled at the end of the cycle
- addr  out  16  registered bus address
- rd  out  1  registered; 1 = addr is a real read this cycle
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- ea  out  16  effective address
- pc_out  out  16  PC after operand bytes
- page_cross  out  1  index add carried out of the low byte

Behaviour:
- Reset (async, any time, including mid-sequence):
  - state=IDLE;
  - addr=0, rd=0, busy=0, done=0, ea=0, pc_out=0, page_cross=0;
  - the aborted sequence never signals done.
- IDLE:
  - start=1 latches bbb, force_fix, pc_in, x and y;
  - next cycle is C1 with busy=1.
  - start while busy is ignored.
  - start in the done cycle is accepted (done and IDLE coincide).
- Cycle sequences. "R a" means addr=a, rd=1, d_in captured; "D" means dummy cycle, rd=0, addr holds.
  - IMM: C1 D. Result: ea=pc, pc_out=pc+1.
  - ZPG: C1 R pc→lo. Result: ea={ZP_BASE,lo}, pc_out=pc+1.
  - ZPX: C1 R pc→lo; C2 D. Result: ea=zp(lo+x), pc_out=pc+1.
  - ABS: C1 R pc→lo; C2 R pc+1→hi. Result: ea={hi,lo}, pc_out=pc+2.
  - ABX/ABY: C1 R pc→lo; C2 R pc+1→hi; s=lo+idx (9 bits).
    - Fix-up needed if s[8] or force_fix or PAGE_PENALTY==0: C3 R {hi,s[7:0]} (dummy read).
    - Result: ea={hi+s[8],s[7:0]}, pc_out=pc+2.
  - INX: C1 R pc→p; C2 D; C3 R zp(p+x)→lo; C4 R zp(p+x+1)→hi. Result: ea={hi,lo}, pc_out=pc+1.
  - INY: C1 R pc→p; C2 R zp(p)→lo; C3 R zp(p+1)→hi; s=lo+y.
    - Fix-up C4 R {hi,s[7:0]} under the same rule as ABX/ABY.
    - Result: ea={hi+s[8],s[7:0]}, pc_out=pc+1.
- zp(v) definition:
  - ZP_WRAP=1: zp(v)={ZP_BASE, v[7:0]}.
  - ZP_WRAP=0: zp(v)={ZP_BASE,8'h00}+v (9-bit v).
- Cycle counts (PAGE_PENALTY=1, no cross): IMM 1, ZPG 1, ZPX 2, ABS 2, ABX/ABY 2(+1), INX 4, INY 3(+1).
- Completion:
  - busy falls after the last C cycle;
  - done=1 for exactly the following cycle;
  - ea, pc_out and page_cross update at that edge and hold until the next completion or reset.
- page_cross = s[8] for ABX/ABY/INY, else 0. It is independent of force_fix.
- ea high byte wraps modulo 2^16: {FF,FF}+1 → 0000.
- Outside busy: rd=0 and addr holds its last value.

Test Plan:
- Reset asserted mid-INX at C3 → all outputs 0 asynchronously; after release, start ABS pc_in=0x0400 with mem[0400]=34, mem[0401]=12 → reads 0400, 0401; done on cycle 3; ea=1234; pc_out=0402.
- ABX, x=0x10, operand bytes F8 12, PAGE_PENALTY=1 → C3 dummy read addr=1208; ea=1308; page_cross=1; done on cycle 4. Same with x=0x01 → ea=12F9; done on cycle 3.
- ZPX, lo=FF, x=02: with ZP_WRAP=1 → ea=0001. Repeat with ZP_WRAP=0 → ea=0101. Repeat with ZP_BASE=20, ZP_WRAP=1 → ea=2001.
- INY pointer at zp FF, mem[00FF]=F0, mem[0000]=30, y=20, ZP_WRAP=1 → reads at 00FF then 0000, fix-up read 3010; ea=3110; 4 busy cycles.
- STA-style ABY (force_fix=1), y=0, operand 00 40 → C3 fix-up still occurs; ea=4000; page_cross=0. With PAGE_PENALTY=0 and force_fix=0 → same 3-cycle timing.
- IMM pc_in=C000 issued with start held high through done → back-to-back sequences; done pulses each 2nd cycle; ea=C000; pc_out=C001; start during busy ignored.
